// File: rtl/passcode_pkg.sv
// Shared definitions for the passcode entry controller: FSM state encoding,
// BCD digit width and a digit legality helper.
package passcode_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_LOCKED = 3'd5
    } state_e;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Rising-edge detector on the keypad encoder's valid bit; a held key yields
// a single press pulse in the cycle the key first appears.
module key_press_detect
    import passcode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       key_code,
    output logic             press,
    output logic [BCD_W-1:0] digit
);

    logic valid_prev_r;

    // Remember last cycle's key-valid bit for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_prev_r <= 1'b0;
        end else begin
            valid_prev_r <= key_code[4];
        end
    end

    assign press = key_code[4] & ~valid_prev_r;
    assign digit = key_code[3:0];

endmodule

// File: rtl/passcode_entry_ctrl.sv
// Keypad passcode controller: digit capture, compare, timed unlock and entry
// timeout. Define PASSCODE_LOCKOUT_EN to add failure counting and lockout.
module passcode_entry_ctrl
    import passcode_pkg::*;
#(
    parameter int          NUM_DIGITS     = 8,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_0000,
    parameter int          OPEN_CYCLES    = 1000,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCK_CYCLES    = 10000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  key_code,
    input  logic        code_load,
    input  logic [31:0] code_in,
    output logic [31:0] entry_out,
    output logic [3:0]  digit_cnt,
    output logic        unlock,
    output logic        locked,
    output logic        alarm,
    output logic [2:0]  state_out
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_param_check
        $error("passcode_entry_ctrl: illegal parameter value");
    end

    localparam int          CODE_W    = BCD_W * NUM_DIGITS;
    localparam logic [31:0] CODE_MASK = (CODE_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << CODE_W) - 32'd1);
    localparam int BASE_MAX = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
`ifdef PASSCODE_LOCKOUT_EN
    localparam int TMR_MAX  = (LOCK_CYCLES > BASE_MAX) ? LOCK_CYCLES : BASE_MAX;
    localparam int FAIL_W   = $clog2(MAX_FAILS + 1);
`else
    localparam int TMR_MAX  = BASE_MAX;
`endif
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    logic             press_s;
    logic [BCD_W-1:0] digit_s;
    logic             digit_ok_s;

    state_e           state_r, state_n;
    logic [31:0]      stored_r, stored_n;
    logic [31:0]      entry_r, entry_n;
    logic [3:0]       cnt_r, cnt_n;
    logic [TMR_W-1:0] timer_r, timer_n;
    logic             unlock_r;
`ifdef PASSCODE_LOCKOUT_EN
    logic [FAIL_W-1:0] fail_r, fail_n;
    logic              locked_r, alarm_r;
`endif

    key_press_detect u_key_press_detect (
        .clk      (clk),
        .rst      (rst),
        .key_code (key_code),
        .press    (press_s),
        .digit    (digit_s)
    );

    assign digit_ok_s = press_s & is_bcd(digit_s);

    // Next-state, datapath and timer decisions
    always_comb begin
        state_n  = state_r;
        stored_n = stored_r;
        entry_n  = entry_r;
        cnt_n    = cnt_r;
        timer_n  = timer_r;
`ifdef PASSCODE_LOCKOUT_EN
        fail_n   = fail_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (code_load) begin
                    stored_n = code_in;
                end else begin
                    stored_n = stored_r;
                end
                if (digit_ok_s) begin
                    entry_n = {{(32-BCD_W){1'b0}}, digit_s};
                    cnt_n   = 4'd1;
                    timer_n = '0;
                    if (NUM_DIGITS == 1) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_ENTRY;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (digit_ok_s) begin
                    entry_n = {entry_r[31-BCD_W:0], digit_s};
                    cnt_n   = cnt_r + 4'd1;
                    timer_n = '0;
                    if ((cnt_r + 4'd1) == 4'(NUM_DIGITS)) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_ENTRY;
                    end
                end else if (timer_r == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    entry_n = '0;
                    cnt_n   = 4'd0;
                    timer_n = '0;
                end else begin
                    timer_n = timer_r + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                timer_n = '0;
                // Only the configured digit count takes part in the compare
                if ((entry_r & CODE_MASK) == (stored_r & CODE_MASK)) begin
                    state_n = ST_OPEN;
`ifdef PASSCODE_LOCKOUT_EN
                    fail_n  = '0;
`endif
                end else begin
                    state_n = ST_FAIL;
                end
            end
            ST_OPEN: begin
                if (timer_r == TMR_W'(OPEN_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    entry_n = '0;
                    cnt_n   = 4'd0;
                    timer_n = '0;
                end else begin
                    timer_n = timer_r + TMR_W'(1);
                end
            end
            ST_FAIL: begin
                entry_n = '0;
                cnt_n   = 4'd0;
                timer_n = '0;
`ifdef PASSCODE_LOCKOUT_EN
                if (int'(fail_r) < MAX_FAILS) begin
                    fail_n = fail_r + FAIL_W'(1);
                end else begin
                    fail_n = fail_r;
                end
                if (int'(fail_r) + 1 >= MAX_FAILS) begin
                    state_n = ST_LOCKED;
                end else begin
                    state_n = ST_IDLE;
                end
`else
                state_n = ST_IDLE;
`endif
            end
`ifdef PASSCODE_LOCKOUT_EN
            ST_LOCKED: begin
                if (timer_r == TMR_W'(LOCK_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                    fail_n  = '0;
                end else begin
                    timer_n = timer_r + TMR_W'(1);
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                entry_n = '0;
                cnt_n   = 4'd0;
                timer_n = '0;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            stored_r <= DEFAULT_CODE;
            entry_r  <= '0;
            cnt_r    <= 4'd0;
            timer_r  <= '0;
            unlock_r <= 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
            fail_r   <= '0;
            locked_r <= 1'b0;
            alarm_r  <= 1'b0;
`endif
        end else begin
            state_r  <= state_n;
            stored_r <= stored_n;
            entry_r  <= entry_n;
            cnt_r    <= cnt_n;
            timer_r  <= timer_n;
            unlock_r <= (state_n == ST_OPEN);
`ifdef PASSCODE_LOCKOUT_EN
            fail_r   <= fail_n;
            locked_r <= (state_n == ST_LOCKED);
            alarm_r  <= (state_n == ST_LOCKED) && (state_r != ST_LOCKED);
`endif
        end
    end

    assign entry_out = entry_r;
    assign digit_cnt = cnt_r;
    assign unlock    = unlock_r;
    assign state_out = state_r;
`ifdef PASSCODE_LOCKOUT_EN
    assign locked    = locked_r;
    assign alarm     = alarm_r;
`else
    assign locked    = 1'b0;
    assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// Scoreboard bench for passcode_entry_ctrl; lockout scenario runs when
// PASSCODE_LOCKOUT_EN is defined.
module tb_passcode_entry_ctrl;

    localparam int ND = 4;
    localparam int OC = 4;
    localparam int TC = 16;
    localparam int MF = 3;
    localparam int LC = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_OPEN   = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;
    localparam logic [2:0] S_LOCKED = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key_code;
    logic        code_load;
    logic [31:0] code_in;
    logic [31:0] entry_out;
    logic [3:0]  digit_cnt;
    logic        unlock;
    logic        locked;
    logic        alarm;
    logic [2:0]  state_out;

    passcode_entry_ctrl #(
        .NUM_DIGITS     (ND),
        .DEFAULT_CODE   (32'h0000_1234),
        .OPEN_CYCLES    (OC),
        .TIMEOUT_CYCLES (TC),
        .MAX_FAILS      (MF),
        .LOCK_CYCLES    (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .code_load (code_load),
        .code_in   (code_in),
        .entry_out (entry_out),
        .digit_cnt (digit_cnt),
        .unlock    (unlock),
        .locked    (locked),
        .alarm     (alarm),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [31:0] entry;
        logic [3:0]  cnt;
        logic        unl;
        logic        lck;
        logic        alm;
        bit          ec;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   open_load_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expected post-edge snapshot, let the edge happen, pop and compare
    task automatic step(input string tag, input logic [2:0] st, input logic [31:0] entry,
                        input logic [3:0] cnt, input logic unl, input logic lck,
                        input logic alm, input bit ec);
        exp_t e;
        exp_t o;
        e.tag = tag; e.st = st; e.entry = entry; e.cnt = cnt;
        e.unl = unl; e.lck = lck; e.alm = alm; e.ec = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check_val({o.tag, ".state"}, 32'(state_out), 32'(o.st));
        check_val({o.tag, ".unlock"}, 32'(unlock), 32'(o.unl));
        check_val({o.tag, ".locked"}, 32'(locked), 32'(o.lck));
        check_val({o.tag, ".alarm"}, 32'(alarm), 32'(o.alm));
        if (o.ec) begin
            check_val({o.tag, ".entry"}, entry_out, o.entry);
            check_val({o.tag, ".cnt"}, 32'(digit_cnt), 32'(o.cnt));
        end
    endtask

    task automatic key_dn(input logic [3:0] d);
        @(negedge clk);
        key_code = {1'b1, d};
    endtask

    task automatic key_up();
        @(negedge clk);
        key_code = 5'd0;
    endtask

    task automatic rel_after(inout int since, input int hold);
        @(negedge clk);
        if (since >= hold) key_code = 5'd0;
        since++;
    endtask

    task automatic idle_steps(input string tag, input int n, input logic [2:0] st,
                              input logic [31:0] entry, input logic [3:0] cnt);
        for (int i = 0; i < n; i++) step(tag, st, entry, cnt, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Enter a full code from IDLE, each key held 'hold' edges, and check the outcome
    task automatic enter_code(input logic [15:0] code, input int hold, input bit ok,
                              input bit lock_after);
        logic [31:0] ent;
        int since;
        ent = 32'd0;
        for (int i = 0; i < ND; i++) begin
            logic [3:0] d;
            d = code[4*(ND-1-i) +: 4];
            ent = {ent[27:0], d};
            key_dn(d);
            if (i < ND - 1) begin
                step("entry", S_ENTRY, ent, 4'(i+1), 1'b0, 1'b0, 1'b0, 1'b1);
                for (int h = 1; h < hold; h++)
                    step("held", S_ENTRY, ent, 4'(i+1), 1'b0, 1'b0, 1'b0, 1'b1);
                key_up();
                step("released", S_ENTRY, ent, 4'(i+1), 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                step("check", S_CHECK, ent, 4'(ND), 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        since = 1;
        if (ok) begin
            for (int j = 0; j < OC; j++) begin
                rel_after(since, hold);
                code_load = open_load_en && (j == 1);
                code_in   = 32'h0000_9999;
                step("open", S_OPEN, ent, 4'(ND), 1'b1, 1'b0, 1'b0, 1'b0);
            end
            rel_after(since, hold);
            code_load = 1'b0;
            step("open_done", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            rel_after(since, hold);
            step("fail", S_FAIL, ent, 4'(ND), 1'b0, 1'b0, 1'b0, 1'b0);
            rel_after(since, hold);
            if (lock_after)
                step("lock_enter", S_LOCKED, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            else
                step("fail_done", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        key_code = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_code = 5'd0; code_load = 1'b0; code_in = 32'd0;
        @(posedge clk);
        step("reset", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Default code, each key held 3 cycles
        enter_code(16'h1234, 3, 1'b1, 1'b0);

        // Key 1 held 20 edges: one capture, timeout while still held, no re-press
        key_dn(4'd1);
        step("hold20", S_ENTRY, 32'h1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps("hold20_entry", TC - 1, S_ENTRY, 32'h1, 4'd1);
        idle_steps("hold20_tmo", 4, S_IDLE, 32'd0, 4'd0);
        key_up();
        step("hold20_rel", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        enter_code(16'h1234, 1, 1'b1, 1'b0);

        // Non-BCD digits are ignored in IDLE and ENTRY
        key_dn(4'hA);
        step("bad_idle", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        step("bad_idle_rel", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        key_dn(4'd7);
        step("bad_first", S_ENTRY, 32'h7, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        step("bad_first_rel", S_ENTRY, 32'h7, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        key_dn(4'hB);
        step("bad_entry", S_ENTRY, 32'h7, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        idle_steps("bad_wait", TC - 3, S_ENTRY, 32'h7, 4'd1);
        step("bad_tmo", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Timeout boundary: 15 idle edges stay in ENTRY, the 16th returns to IDLE
        key_dn(4'd1);
        step("to_d1", S_ENTRY, 32'h1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        step("to_d1_rel", S_ENTRY, 32'h1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        key_dn(4'd2);
        step("to_d2", S_ENTRY, 32'h12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        idle_steps("to_wait", TC - 1, S_ENTRY, 32'h12, 4'd2);
        step("to_expire", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Three wrong codes
        enter_code(16'h9999, 1, 1'b0, 1'b0);
        enter_code(16'h9999, 1, 1'b0, 1'b0);
`ifdef PASSCODE_LOCKOUT_EN
        enter_code(16'h9999, 1, 1'b0, 1'b1);
        for (int j = 1; j < LC; j++) begin
            @(negedge clk);
            if (j == 2 || j == 6) key_code = {1'b1, 4'd1};
            else if (j == 3) key_code = 5'd0;
            step("locked", S_LOCKED, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        step("lock_done", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lock_held", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        key_up();
        step("lock_rel", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        enter_code(16'h9999, 1, 1'b0, 1'b0);
`endif
        enter_code(16'h1234, 1, 1'b1, 1'b0);

        // Code load in IDLE; a load during OPEN must not take effect
        @(negedge clk);
        code_load = 1'b1;
        code_in   = 32'h0000_5678;
        step("load", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        code_load = 1'b0;
        enter_code(16'h1234, 1, 1'b0, 1'b0);
        open_load_en = 1'b1;
        enter_code(16'h5678, 1, 1'b1, 1'b0);
        open_load_en = 1'b0;
        enter_code(16'h5678, 1, 1'b1, 1'b0);

        // Reset mid-entry restores default code and clears everything
        for (int i = 1; i <= 3; i++) begin
            key_dn(4'(i));
            key_up();
        end
        step("pre_rst", S_ENTRY, 32'h123, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step("mid_rst", S_IDLE, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        enter_code(16'h1234, 1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
